// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU operations, FSM states and decoded instruction classes.
package mips_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LW   = 3'd1,
    C_SW   = 3'd2,
    C_BEQ  = 3'd3,
    C_ADDI = 3'd4,
    C_J    = 3'd5,
    C_BAD  = 3'd6
  } iclass_e;

endpackage

// File: rtl/mips_decoder.sv
// Combinational instruction decode: classifies the IR fields and flags
// unsupported encodings or register fields beyond the implemented file.
module mips_decoder
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [5:0]        i_op,
  input  logic [5:0]        i_funct,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  output alu_op_e           o_alu_op,
  output logic              o_alu_src_imm,
  output logic              o_wb_sel_mem,
  output logic [REG_AW-1:0] o_rd,
  output iclass_e           o_class,
  output logic              o_illegal_instr,
  output logic              o_reg_range_err
);

  logic w_rs_bad, w_rt_bad, w_rd_bad;

  // One extra bit so NUM_REGS = 32 still compares correctly.
  assign w_rs_bad = {1'b0, i_rs} >= 6'(NUM_REGS);
  assign w_rt_bad = {1'b0, i_rt} >= 6'(NUM_REGS);
  assign w_rd_bad = {1'b0, i_rd} >= 6'(NUM_REGS);

  always_comb begin
    o_class       = C_BAD;
    o_alu_op      = ALU_ADD;
    o_alu_src_imm = 1'b0;
    o_wb_sel_mem  = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_class = C_R;
        case (i_funct)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_SLT:  o_alu_op = ALU_SLT;
          default: o_class  = C_BAD;
        endcase
      end
      OP_LW: begin
        o_class       = C_LW;
        o_alu_src_imm = 1'b1;
        o_wb_sel_mem  = 1'b1;
      end
      OP_SW: begin
        o_class       = C_SW;
        o_alu_src_imm = 1'b1;
      end
      OP_BEQ: begin
        o_class  = C_BEQ;
        o_alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        o_class       = C_ADDI;
        o_alu_src_imm = 1'b1;
      end
      OP_J:    o_class = C_J;
      default: o_class = C_BAD;
    endcase
  end

  assign o_rd            = (i_op == OP_RTYPE) ? i_rd : i_rt;
  assign o_illegal_instr = (o_class == C_BAD);

  // Only fields the instruction actually uses are range-checked.
  always_comb begin
    o_reg_range_err = 1'b0;
    case (o_class)
      C_R:                         o_reg_range_err = w_rs_bad | w_rt_bad | w_rd_bad;
      C_LW, C_SW, C_BEQ, C_ADDI:   o_reg_range_err = w_rs_bad | w_rt_bad;
      default:                     o_reg_range_err = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control: owns PC and IR, sequences fetch/decode/exec/
// mem/writeback with memory handshakes, and traps on bad code or timeouts.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  alu_zero,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  imem_req,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [REG_AW-1:0]     rf_rs,
  output logic [REG_AW-1:0]     rf_rt,
  output logic [REG_AW-1:0]     rf_rd,
  output logic                  rf_we,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic [2:0]            alu_op,
  output logic                  alu_src_imm,
  output logic                  wb_sel_mem,
  output logic                  illegal,
  output logic [2:0]            state
);

  localparam int unsigned     TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_ir, w_ir_nxt;
  logic [TMO_W-1:0]      r_tmo, w_tmo_nxt;
  logic                  r_illegal, w_illegal_nxt;

  alu_op_e               w_alu_op;
  iclass_e               w_class;
  logic                  w_illegal_instr, w_reg_range_err;
  logic [REG_AW-1:0]     w_rd;

  mips_decoder #(.NUM_REGS(NUM_REGS)) u_dec (
    .i_op            (r_ir[31:26]),
    .i_funct         (r_ir[5:0]),
    .i_rs            (r_ir[25:21]),
    .i_rt            (r_ir[20:16]),
    .i_rd            (r_ir[15:11]),
    .o_alu_op        (w_alu_op),
    .o_alu_src_imm   (alu_src_imm),
    .o_wb_sel_mem    (wb_sel_mem),
    .o_rd            (w_rd),
    .o_class         (w_class),
    .o_illegal_instr (w_illegal_instr),
    .o_reg_range_err (w_reg_range_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_tmo     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_tmo     <= w_tmo_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Timeout count defaults to zero, so it clears on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_tmo_nxt     = '0;
    w_illegal_nxt = r_illegal;
    case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          w_ir_nxt    = imem_rdata;
          w_pc_nxt    = r_pc + DATA_WIDTH'(4);
          w_state_nxt = S_DECODE;
        end else if (r_tmo == TMO_LAST) begin
          w_illegal_nxt = 1'b1;
          w_state_nxt   = S_TRAP;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_DECODE: begin
        if (w_class == C_J) begin
          w_pc_nxt    = {r_pc[DATA_WIDTH-1:28], r_ir[25:0], 2'b00};
          w_state_nxt = S_FETCH;
        end else if (w_illegal_instr || w_reg_range_err) begin
          w_illegal_nxt = 1'b1;
          w_state_nxt   = S_TRAP;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_class)
          C_BEQ: begin
            if (alu_zero) w_pc_nxt = r_pc + {imm_ext[DATA_WIDTH-3:0], 2'b00};
            w_state_nxt = S_FETCH;
          end
          C_LW, C_SW: w_state_nxt = S_MEM;
          default:    w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          w_state_nxt = (w_class == C_SW) ? S_FETCH : S_WB;
        end else if (r_tmo == TMO_LAST) begin
          w_illegal_nxt = 1'b1;
          w_state_nxt   = S_TRAP;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_TRAP:  w_state_nxt = S_TRAP;
      default: begin
        w_illegal_nxt = 1'b1;
        w_state_nxt   = S_TRAP;
      end
    endcase
  end

  // Reset parks the FSM in FETCH, so the fetch request is masked by rst.
  assign imem_req = ~rst & (r_state == S_FETCH);
  assign dmem_req = (r_state == S_MEM);
  assign dmem_we  = (r_state == S_MEM) & (w_class == C_SW);
  assign rf_we    = (r_state == S_WB);
  assign rf_rs    = r_ir[25:21];
  assign rf_rt    = r_ir[20:16];
  assign rf_rd    = w_rd;
  assign imm_ext  = {{(DATA_WIDTH-16){r_ir[15]}}, r_ir[15:0]};
  assign alu_op   = w_alu_op;
  assign pc       = r_pc;
  assign illegal  = r_illegal;
  assign state    = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: steps the FSM through each instruction
// class, traps, timeouts and asynchronous reset with hand-computed expectations.
module tb_mips_mc_control;

  logic        clk;
  logic        rst;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_ready;
  logic        alu_zero;
  logic [31:0] pc;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic [4:0]  rf_rs;
  logic [4:0]  rf_rt;
  logic [4:0]  rf_rd;
  logic        rf_we;
  logic [31:0] imm_ext;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        wb_sel_mem;
  logic        illegal;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  mips_mc_control dut (
    .clk         (clk),
    .rst         (rst),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .alu_zero    (alu_zero),
    .pc          (pc),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .rf_rs       (rf_rs),
    .rf_rt       (rf_rt),
    .rf_rd       (rf_rd),
    .rf_we       (rf_we),
    .imm_ext     (imm_ext),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .wb_sel_mem  (wb_sel_mem),
    .illegal     (illegal),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; imem_rdata = '0;
    repeat (2) step();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    n_tests++; if ({imem_req, dmem_req, dmem_we, rf_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_reqs: got %b expected 0000", {imem_req, dmem_req, dmem_we, rf_we}); end
    n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    rst = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_imem_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_addi();
    step();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL addi_wait_state: got %0d expected 0", state); end
    imem_ready = 1'b1; imem_rdata = 32'h2023_0005;
    step();
    imem_ready = 1'b0;
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL addi_decode_state: got %0d expected 1", state); end
    n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL addi_pc: got %h expected 00000004", pc); end
    n_tests++; if ({rf_rs, rf_rt} !== {5'd1, 5'd3}) begin n_fail++; $display("FAIL addi_rs_rt: got %0d,%0d expected 1,3", rf_rs, rf_rt); end
    n_tests++; if (imm_ext !== 32'h5) begin n_fail++; $display("FAIL addi_imm: got %h expected 00000005", imm_ext); end
    step();
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL addi_exec_state: got %0d expected 2", state); end
    n_tests++; if ({alu_src_imm, alu_op, rf_we} !== 5'b1_000_0) begin
      n_fail++; $display("FAIL addi_exec_ctl: got src=%b op=%0d we=%b expected 1,0,0", alu_src_imm, alu_op, rf_we); end
    step();
    n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL addi_wb_state: got %0d expected 4", state); end
    n_tests++; if ({rf_we, rf_rd, wb_sel_mem, imem_req, dmem_req} !== {1'b1, 5'd3, 3'b000}) begin
      n_fail++; $display("FAIL addi_wb_ctl: got we=%b rd=%0d sel=%b ireq=%b dreq=%b expected 1,3,0,0,0",
                         rf_we, rf_rd, wb_sel_mem, imem_req, dmem_req); end
    step();
    n_tests++; if ({state, rf_we} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL addi_back_fetch: got st=%0d we=%b expected 0,0", state, rf_we); end
  endtask

  task automatic test_add();
    imem_ready = 1'b1; imem_rdata = 32'h0022_2020;
    step();
    imem_ready = 1'b0;
    n_tests++; if ({state, rf_rs, rf_rt} !== {3'd1, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL add_decode: got st=%0d rs=%0d rt=%0d expected 1,1,2", state, rf_rs, rf_rt); end
    n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL add_pc: got %h expected 00000008", pc); end
    step();
    n_tests++; if ({alu_op, alu_src_imm} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL add_exec: got op=%0d src=%b expected 0,0", alu_op, alu_src_imm); end
    step();
    n_tests++; if ({state, rf_we, rf_rd} !== {3'd4, 1'b1, 5'd4}) begin
      n_fail++; $display("FAIL add_wb: got st=%0d we=%b rd=%0d expected 4,1,4", state, rf_we, rf_rd); end
    step();
  endtask

  task automatic test_beq_jump();
    logic we_seen;
    we_seen = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h1022_0003;
    step(); we_seen |= rf_we;
    imem_ready = 1'b0;
    n_tests++; if (pc !== 32'hC) begin n_fail++; $display("FAIL beq_decode_pc: got %h expected 0000000c", pc); end
    alu_zero = 1'b1;
    step(); we_seen |= rf_we;
    n_tests++; if ({state, alu_op} !== {3'd2, 3'd1}) begin
      n_fail++; $display("FAIL beq_exec: got st=%0d op=%0d expected 2,1", state, alu_op); end
    step(); we_seen |= rf_we;
    alu_zero = 1'b0;
    n_tests++; if ({state, pc} !== {3'd0, 32'h18}) begin
      n_fail++; $display("FAIL beq_taken: got st=%0d pc=%h expected 0,00000018", state, pc); end
    imem_ready = 1'b1; imem_rdata = 32'h0800_0002;
    step(); we_seen |= rf_we;
    imem_ready = 1'b0;
    step(); we_seen |= rf_we;
    n_tests++; if ({state, pc} !== {3'd0, 32'h8}) begin
      n_fail++; $display("FAIL j_target: got st=%0d pc=%h expected 0,00000008", state, pc); end
    imem_ready = 1'b1; imem_rdata = 32'h1022_0003;
    step(); we_seen |= rf_we;
    imem_ready = 1'b0;
    step(); we_seen |= rf_we;
    step(); we_seen |= rf_we;
    n_tests++; if ({state, pc} !== {3'd0, 32'hC}) begin
      n_fail++; $display("FAIL beq_not_taken: got st=%0d pc=%h expected 0,0000000c", state, pc); end
    n_tests++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL beq_rf_we: got %b expected 0", we_seen); end
  endtask

  task automatic test_lw();
    int   nreq;
    logic we_seen;
    nreq = 0; we_seen = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h8C25_0004;
    step();
    imem_ready = 1'b0;
    n_tests++; if ({pc, rf_rs, rf_rt} !== {32'h10, 5'd1, 5'd5}) begin
      n_fail++; $display("FAIL lw_decode: got pc=%h rs=%0d rt=%0d expected 00000010,1,5", pc, rf_rs, rf_rt); end
    step();
    n_tests++; if ({alu_op, alu_src_imm} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL lw_exec: got op=%0d src=%b expected 0,1", alu_op, alu_src_imm); end
    step();
    for (int i = 0; i < 4; i++) begin
      if (dmem_req === 1'b1) nreq++;
      we_seen |= dmem_we;
      if (i == 3) dmem_ready = 1'b1;
      step();
    end
    dmem_ready = 1'b0;
    n_tests++; if (nreq != 4) begin n_fail++; $display("FAIL lw_dmem_req_cycles: got %0d expected 4", nreq); end
    n_tests++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL lw_dmem_we: got %b expected 0", we_seen); end
    n_tests++; if ({state, rf_we, rf_rd, wb_sel_mem, dmem_req} !== {3'd4, 1'b1, 5'd5, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL lw_wb: got st=%0d we=%b rd=%0d sel=%b dreq=%b expected 4,1,5,1,0",
                         state, rf_we, rf_rd, wb_sel_mem, dmem_req); end
    step();
    n_tests++; if ({state, pc} !== {3'd0, 32'h10}) begin
      n_fail++; $display("FAIL lw_done: got st=%0d pc=%h expected 0,00000010", state, pc); end
  endtask

  task automatic test_sw_reset();
    imem_ready = 1'b1; imem_rdata = 32'hAC26_0008;
    step();
    imem_ready = 1'b0;
    step();
    step();
    n_tests++; if ({state, dmem_req, dmem_we} !== {3'd3, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sw_mem: got st=%0d req=%b we=%b expected 3,1,1", state, dmem_req, dmem_we); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({dmem_req, dmem_we, imem_req} !== 3'b000) begin
      n_fail++; $display("FAIL sw_async_reset_reqs: got %b expected 000", {dmem_req, dmem_we, imem_req}); end
    n_tests++; if ({state, pc} !== {3'd0, 32'h0}) begin
      n_fail++; $display("FAIL sw_async_reset_pc: got st=%0d pc=%h expected 0,00000000", state, pc); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_illegal(input logic [31:0] instr, input string name);
    logic any_en;
    any_en = 1'b0;
    imem_ready = 1'b1; imem_rdata = instr;
    step();
    imem_ready = 1'b0;
    step();
    n_tests++; if ({state, illegal} !== {3'd7, 1'b1}) begin
      n_fail++; $display("FAIL %s_trap: got st=%0d ill=%b expected 7,1", name, state, illegal); end
    repeat (3) begin
      any_en |= rf_we | imem_req | dmem_req;
      step();
    end
    n_tests++; if (any_en !== 1'b0) begin n_fail++; $display("FAIL %s_trap_enables: got %b expected 0", name, any_en); end
    n_tests++; if ({state, pc} !== {3'd7, 32'h4}) begin
      n_fail++; $display("FAIL %s_trap_frozen: got st=%0d pc=%h expected 7,00000004", name, state, pc); end
    do_reset();
    n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL %s_reset_clears: got %b expected 0", name, illegal); end
  endtask

  task automatic test_timeout_ready_wins();
    do_reset();
    repeat (254) step();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL tmo_edge_pre: got %0d expected 0", state); end
    imem_ready = 1'b1; imem_rdata = 32'h2023_0005;
    step();
    imem_ready = 1'b0;
    n_tests++; if ({state, illegal} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL tmo_ready_wins: got st=%0d ill=%b expected 1,0", state, illegal); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (254) step();
    n_tests++; if ({state, illegal} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL tmo_pre: got st=%0d ill=%b expected 0,0", state, illegal); end
    step();
    n_tests++; if ({state, illegal, imem_req} !== {3'd7, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL tmo_trap: got st=%0d ill=%b ireq=%b expected 7,1,0", state, illegal, imem_req); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_add();
    test_beq_jump();
    test_lw();
    test_sw_reset();
    test_illegal(32'h0022_8820, "reg_range");
    test_illegal(32'hFC00_0000, "bad_opcode");
    test_timeout_ready_wins();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
